mac_issue: RTL
==============

# mac_issue

Operand-issue and sequencing stage that sits directly upstream of the MAC datapath in the ARM7TDMI core. It accepts a decoded MUL/MLA instruction, fetches Rm, Rs and (for MLA) Rn through a single register-file read port, and drives the MAC's `in1`/`in2`/`acc` inputs. It holds those inputs for the ARM7-accurate number of multiply cycles, then captures the MAC result and N/Z flags and hands them to writeback over a valid/ready handshake.

## Interface
Parameters:
- `DATA_W`, 32, operand/result width
- `REG_AW`, 4, register index width

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `instr_valid`  in  1  decoded multiply instruction present
- `instr_ready`  out  1  block can accept an instruction
- `instr_rd`, `instr_rn`, `instr_rs`, `instr_rm`  in  REG_AW each  register indices
- `instr_acc`  in  1  1 = MLA (accumulate Rn), 0 = MUL
- `instr_s`  in  1  S bit, update flags
- `rf_raddr`  out  REG_AW  register-file read address
- `rf_rdata`  in  DATA_W  read data, combinational, same cycle
- `mac_in1`, `mac_in2`, `mac_acc`  out  DATA_W  operands to MAC
- `mac_result`  in  DATA_W  MAC result
- `mac_zero_flag`, `mac_negative_flag`  in  1  MAC flags (carry/overflow unused)
- `wb_valid`  out  1  writeback data valid
- `wb_ready`  in  1  writeback accepts
- `wb_rd`  out  REG_AW  destination register
- `wb_data`  out  DATA_W  product/sum
- `wb_flags_we`  out  1  = latched S bit
- `wb_n`, `wb_z`  out  1  flags
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, RD_RM, RD_RS, RD_RN, MUL, WB.
- IDLE: `instr_ready`=1. On `instr_valid && instr_ready`, latch all fields and go to RD_RM.
- RD_RM: `rf_raddr`=rm; capture `rf_rdata` into op_a; go to RD_RS.
- RD_RS: `rf_raddr`=rs; capture op_b; load cycle counter with m(op_b); go to RD_RN if acc, else clear op_acc and go to MUL.
- RD_RN: `rf_raddr`=rn; capture op_acc; go to MUL.
- m(rs): 1 if rs[31:8] all 0s or all 1s; 2 if rs[31:16] all 0s/1s; 3 if rs[31:24] all 0s/1s; else 4.
- MUL: `mac_in1`=op_a, `mac_in2`=op_b, `mac_acc`=op_acc, held constant. Counter decrements each cycle. In the cycle where counter==1, register `mac_result` into `wb_data`, the flags into `wb_n`/`wb_z`, and go to WB.
- WB: `wb_valid`=1, with all `wb_*` stable until `wb_ready`; on handshake go to IDLE.
- `rf_raddr`=0 in IDLE, MUL and WB. MAC operand registers keep their last value outside MUL.
- rd==rm or rd==rs needs no special handling: operands are already latched.

## Timing
- Reset: state IDLE, `instr_ready`=1, `busy`=0, `wb_valid`=0, all data/flag/address outputs and counter = 0.
- Accept edge E0 → RD_RM. MUL is entered at E(2+a), where a=instr_acc. WB is entered and `wb_valid` rises at edge E(2+a+m).
- One instruction in flight. Next accept is possible at the edge after WB handshake plus one IDLE cycle.
- `wb_ready` low: stay in WB indefinitely, with outputs unchanged.
- `rst_n` low in any state: IDLE next edge and the instruction is discarded. A held `wb_valid` drops.
- `instr_valid` while busy: ignored, not latched.

## Configuration
- `MAC_EARLY_TERM_EN` defined: m per the early-termination rule above.
- Not defined: m=4 for every instruction, and the m-compute logic is removed.

## Structure
- Package `mac_pkg`: FSM state enum, `DATA_W`/`REG_AW` defaults, m-cycle constants (M_MAX=4, counter width 3).
- Sub-module `mac_mcycle`: combinational rs → m (1–4), instantiated only under `MAC_EARLY_TERM_EN`.

## Test plan
- MUL, rm=3, rs=5, S=1 → `wb_data`=15, n=0, z=0, `wb_flags_we`=1, `wb_valid` at E3.
- MLA, rm=7, rs=0x00010000, rn=100 → `wb_data`=0x70064, m=3, `wb_valid` at E6.
- MUL, rm=1, rs=0xFFFFFFFF, S=0 → `wb_data`=0xFFFFFFFF, m=1, `wb_flags_we`=0; a repeat with rm=0, S=1 gives z=1.
- rs=0x12345678 → m=4, `wb_valid` at E6. With macro undefined, the case rs=5 also gives `wb_valid` at E6.
- `wb_ready` held low for 5 cycles in WB → `wb_*` stable, `instr_ready`=0, a pending `instr_valid` is ignored. After the handshake the next instruction is accepted.
- `rst_n` low for one cycle during MUL → IDLE next edge, `wb_valid` never asserts, `instr_ready`=1.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and constants for the multiply operand-issue stage.
package mac_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_AW_DEF = 4;
  localparam int unsigned M_MAX      = 4;
  localparam int unsigned CNT_W      = 3;

  typedef enum logic [2:0] {
    StIdle,
    StRdRm,
    StRdRs,
    StRdRn,
    StMul,
    StWb
  } state_e;

endpackage

// File: rtl/mac_mcycle.sv
// Early-termination multiply cycle count: fewer cycles when Rs upper bytes are sign-uniform.
module mac_mcycle
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] rs_i,
  output logic [CNT_W-1:0]  m_o
);

  logic uni8, uni16, uni24;

  assign uni8  = (&rs_i[DATA_W-1:8])  | ~(|rs_i[DATA_W-1:8]);
  assign uni16 = (&rs_i[DATA_W-1:16]) | ~(|rs_i[DATA_W-1:16]);
  assign uni24 = (&rs_i[DATA_W-1:24]) | ~(|rs_i[DATA_W-1:24]);

  always_comb begin
    m_o = CNT_W'(M_MAX);
    if (uni8) begin
      m_o = CNT_W'(1);
    end else if (uni16) begin
      m_o = CNT_W'(2);
    end else if (uni24) begin
      m_o = CNT_W'(3);
    end
  end

endmodule

// File: rtl/mac_issue.sv
// MUL/MLA operand fetch, multiply-cycle sequencing and writeback handshake.
// Optional MAC_EARLY_TERM_EN: data-dependent cycle count; otherwise always M_MAX cycles.
module mac_issue
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rn,
  input  logic [REG_AW-1:0] instr_rs,
  input  logic [REG_AW-1:0] instr_rm,
  input  logic              instr_acc,
  input  logic              instr_s,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [DATA_W-1:0] mac_in1,
  output logic [DATA_W-1:0] mac_in2,
  output logic [DATA_W-1:0] mac_acc,
  input  logic [DATA_W-1:0] mac_result,
  input  logic              mac_zero_flag,
  input  logic              mac_negative_flag,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_flags_we,
  output logic              wb_n,
  output logic              wb_z,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [REG_AW-1:0] rd_q, rd_d, rn_q, rn_d, rs_q, rs_d, rm_q, rm_d;
  logic              is_mla_q, is_mla_d, s_q, s_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [DATA_W-1:0] in1_q, in1_d, in2_q, in2_d, op_acc_q, op_acc_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_n_q, wb_n_d, wb_z_q, wb_z_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  m_cycles;

`ifdef MAC_EARLY_TERM_EN
  // Rs is on the read port during StRdRs, so m is derived from the live read data.
  mac_mcycle #(
    .DATA_W (DATA_W)
  ) u_mcycle (
    .rs_i (rf_rdata),
    .m_o  (m_cycles)
  );
`else
  assign m_cycles = CNT_W'(M_MAX);
`endif

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    rn_d      = rn_q;
    rs_d      = rs_q;
    rm_d      = rm_q;
    is_mla_d  = is_mla_q;
    s_d       = s_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    op_acc_d  = op_acc_q;
    wb_data_d = wb_data_q;
    wb_n_d    = wb_n_q;
    wb_z_d    = wb_z_q;
    cnt_d     = cnt_q;
    rf_raddr  = '0;
    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          rd_d     = instr_rd;
          rn_d     = instr_rn;
          rs_d     = instr_rs;
          rm_d     = instr_rm;
          is_mla_d = instr_acc;
          s_d      = instr_s;
          state_d  = StRdRm;
        end
      end
      StRdRm: begin
        rf_raddr = rm_q;
        op_a_d   = rf_rdata;
        state_d  = StRdRs;
      end
      StRdRs: begin
        rf_raddr = rs_q;
        op_b_d   = rf_rdata;
        cnt_d    = m_cycles;
        if (is_mla_q) begin
          state_d = StRdRn;
        end else begin
          in1_d    = op_a_q;
          in2_d    = rf_rdata;
          op_acc_d = '0;
          state_d  = StMul;
        end
      end
      StRdRn: begin
        rf_raddr = rn_q;
        in1_d    = op_a_q;
        in2_d    = op_b_q;
        op_acc_d = rf_rdata;
        state_d  = StMul;
      end
      StMul: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          wb_data_d = mac_result;
          wb_n_d    = mac_negative_flag;
          wb_z_d    = mac_zero_flag;
          state_d   = StWb;
        end
      end
      StWb: begin
        if (wb_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rd_q      <= '0;
      rn_q      <= '0;
      rs_q      <= '0;
      rm_q      <= '0;
      is_mla_q  <= 1'b0;
      s_q       <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      op_acc_q  <= '0;
      wb_data_q <= '0;
      wb_n_q    <= 1'b0;
      wb_z_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      rn_q      <= rn_d;
      rs_q      <= rs_d;
      rm_q      <= rm_d;
      is_mla_q  <= is_mla_d;
      s_q       <= s_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      op_acc_q  <= op_acc_d;
      wb_data_q <= wb_data_d;
      wb_n_q    <= wb_n_d;
      wb_z_q    <= wb_z_d;
      cnt_q     <= cnt_d;
    end
  end

  assign instr_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign wb_valid    = (state_q == StWb);
  assign mac_in1     = in1_q;
  assign mac_in2     = in2_q;
  assign mac_acc     = op_acc_q;
  assign wb_rd       = rd_q;
  assign wb_data     = wb_data_q;
  assign wb_flags_we = s_q;
  assign wb_n        = wb_n_q;
  assign wb_z        = wb_z_q;

endmodule
